demux2_hs: RTL and testbench

//  Handshaked 1-to-2 demultiplexer: the steering counterpart of the 2:1 select muxes in the SISC datapath.

---
 rtl/demux2_hs.sv | 108 ++++++++++
 tb/tb_demux2_hs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_hs.sv
// demux2_hs: handshaked 1-to-2 demultiplexer with a small in-order FIFO.
//
// Accepts one WIDTH-bit word plus a destination select per transfer and
// delivers it on output A (sel=0) or output B (sel=1), strictly in order
// across both outputs. The outputs always show the registered head entry,
// so there is no combinational path from the input side to the outputs.
//
// Ports
//   clk, rst_f                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake; in_ready is from registered state only
//   in_sel, in_data             destination select and word, sampled together
//   out_a_valid/ready/data      consumer A (head entry with sel=0)
//   out_b_valid/ready/data      consumer B (head entry with sel=1)
//   cnt_clr, cnt_a, cnt_b       delivery counters, present only with DEMUX_CNT_EN
//
// Build option: define DEMUX_CNT_EN to add the per-output delivery counters.
module demux2_hs #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [WIDTH-1:0] out_b_data
`ifdef DEMUX_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [WIDTH:0] mem_q [DEPTH];
    logic [WIDTH:0] mem_d [DEPTH];
    logic [WIDTH:0] head;
    logic           nonempty, push, pop;

    // Each entry is {sel, data}; pointers wrap for free since DEPTH is a power of 2.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        nonempty    = count_q != '0;
        in_ready    = count_q != (AW+1)'(DEPTH);
        out_a_valid = nonempty & ~head[WIDTH];
        out_b_valid = nonempty & head[WIDTH];
        out_a_data  = head[WIDTH-1:0];
        out_b_data  = head[WIDTH-1:0];
        push        = in_valid & in_ready;
        pop         = (out_a_valid & out_a_ready) | (out_b_valid & out_b_ready);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = {in_sel, in_data};
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_comb begin
        cnt_a_d = cnt_clr ? '0 : cnt_a_q + CNT_W'(out_a_valid & out_a_ready);
        cnt_b_d = cnt_clr ? '0 : cnt_b_q + CNT_W'(out_b_valid & out_b_ready);
        cnt_a   = cnt_a_q;
        cnt_b   = cnt_b_q;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end
`endif

endmodule

// File: tb/tb_demux2_hs.sv
// tb_demux2_hs: scoreboard bench for demux2_hs with a queue reference model.
module tb_demux2_hs;

    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 0, rst_f = 1, in_valid = 0, in_sel = 0;
    logic         out_a_ready = 0, out_b_ready = 0, rnd_rdy = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_a_valid, out_b_valid;
    logic [W-1:0] out_a_data, out_b_data;
`ifdef DEMUX_CNT_EN
    logic         cnt_clr = 0;
    logic [7:0]   cnt_a, cnt_b;
    logic [7:0]   m_cnt_a = 0, m_cnt_b = 0;
`endif

    int           compared = 0, mismatched = 0;
    logic [W:0]   q[$];

    demux2_hs #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_f(rst_f),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_data(out_a_data),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_data(out_b_data)
`ifdef DEMUX_CNT_EN
        , .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    // Monitor: compare DUT outputs to the queue model, then apply this cycle's transfers.
    always @(negedge clk) begin : mon
        logic [W:0] h;
        logic       ne, ap, bp, acc;
        if (!rst_f) begin
            q.delete();
`ifdef DEMUX_CNT_EN
            m_cnt_a = 0;
            m_cnt_b = 0;
`endif
        end else begin
            ne = q.size() != 0;
            h  = ne ? q[0] : '0;
            chk("in_ready", in_ready, q.size() < D);
            chk("a_valid", out_a_valid, ne && !h[W]);
            chk("b_valid", out_b_valid, ne && h[W]);
            if (ne) begin
                chk("a_data", out_a_data, h[W-1:0]);
                chk("b_data", out_b_data, h[W-1:0]);
            end
            ap  = ne && !h[W] && out_a_ready;
            bp  = ne && h[W] && out_b_ready;
            acc = in_valid && q.size() < D;
`ifdef DEMUX_CNT_EN
            chk("cnt_a", cnt_a, m_cnt_a);
            chk("cnt_b", cnt_b, m_cnt_b);
            m_cnt_a = cnt_clr ? 8'd0 : m_cnt_a + 8'(ap);
            m_cnt_b = cnt_clr ? 8'd0 : m_cnt_b + 8'(bp);
`endif
            if (ap || bp) void'(q.pop_front());
            if (acc) q.push_back({in_sel, in_data});
        end
    end

    always @(posedge clk) if (rnd_rdy) begin
        #1;
        out_a_ready = 1'($urandom_range(0, 1));
        out_b_ready = 1'($urandom_range(0, 1));
    end

    // Present a word (called at posedge+1) and return at posedge+1 after it is taken.
    task automatic send(input logic s, input logic [W-1:0] d);
        int n = 0;
        in_valid = 1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            mismatched++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, out_a_valid, 0);
        chk({tag, "_b_valid"}, out_b_valid, 0);
        chk({tag, "_a_data"}, out_a_data, 0);
        chk({tag, "_b_data"}, out_b_data, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_f = 0;
        #1 chk_reset_outputs("reset");
        step(2);
        rst_f = 1;
        step(1);

        // Single word to A with both consumers ready.
        out_a_ready = 1;
        out_b_ready = 1;
        send(0, 16'h1234);
        in_valid = 0;
        chk("t2_a_valid", out_a_valid, 1);
        chk("t2_a_data", out_a_data, 16'h1234);
        chk("t2_b_valid", out_b_valid, 0);
        step(1);
`ifdef DEMUX_CNT_EN
        chk("t2_cnt_a", cnt_a, 1);
`endif

        // Fill, refuse third word, head B blocks A.
        out_a_ready = 0;
        out_b_ready = 0;
        in_valid = 1; in_sel = 1; in_data = 16'hAAAA;
        step(1);
        in_sel = 0; in_data = 16'h5555;
        step(1);
        in_sel = 0; in_data = 16'h7777;
        chk("t3_refuse", in_ready, 0);
        out_a_ready = 1;
        step(2);
        chk("t3_b_head", out_b_valid, 1);
        chk("t3_b_data", out_b_data, 16'hAAAA);
        chk("t3_a_blocked", out_a_valid, 0);
        out_b_ready = 1;
        step(1);
        chk("t3_a_next", out_a_valid, 1);
        chk("t3_a_data", out_a_data, 16'h5555);
        send(0, 16'h7777);
        in_valid = 0;
        step(3);

        // Hold one word queued, then stream 8 alternating words with push+pop each cycle.
        out_a_ready = 0;
        out_b_ready = 0;
        send(1, 16'h0F00);
        out_a_ready = 1;
        out_b_ready = 1;
        for (int i = 0; i < 8; i++) begin
            send(1'(i), 16'h0F01 + 16'(i));
            chk("t4_no_stall", in_ready, 1);
        end
        in_valid = 0;
        step(3);

        // Reset with two words queued: nothing stale may come out afterwards.
        out_a_ready = 0;
        out_b_ready = 0;
        send(0, 16'hDEAD);
        send(1, 16'hBEEF);
        in_valid = 0;
        #3 rst_f = 0;
        #1 chk_reset_outputs("t5");
        step(1);
        rst_f = 1;
        out_a_ready = 1;
        out_b_ready = 1;
        step(4);
        chk("t5_no_stale", out_a_valid | out_b_valid, 0);

        // Randomized traffic with random consumer readiness.
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), W'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 0;
                step($urandom_range(1, 3));
            end
        end
        in_valid = 0;
        rnd_rdy = 0;
        step(1);
        out_a_ready = 1;
        out_b_ready = 1;
        step(6);

`ifdef DEMUX_CNT_EN
        // 256 A pops wrap cnt_a back to 0; clear beats a same-cycle B pop.
        cnt_clr = 1;
        step(1);
        cnt_clr = 0;
        for (int i = 0; i < 256; i++) send(0, 16'(i));
        in_valid = 0;
        step(3);
        chk("t6_cnt_a_wrap", cnt_a, 0);
        out_b_ready = 0;
        send(1, 16'h4242);
        send(1, 16'h4343);
        in_valid = 0;
        out_b_ready = 1;
        step(1);
        chk("t6_cnt_b_pre", cnt_b, 1);
        cnt_clr = 1;
        step(1);
        cnt_clr = 0;
        chk("t6_cnt_b_clr", cnt_b, 0);
        step(3);
`endif

        chk("drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
